controle_varredura_servo: RTL
=============================

Name: controle_varredura_servo

Overview:
- Upstream sequencer for the turret servo PWM stage.
- Steps the 5-bit servo position index back and forth between 0 and POS_MAX.
- At each position it waits a settling time, then fires a one-cycle measurement request to the distance sensor and waits for its completion pulse before moving on.
- `posicao` drives the PWM stage's `largura` input directly.

Parameters:
- POS_MAX, 28: last valid position index; legal range 1..31.
- T_ASSENTAMENTO, 25000000: settle time in clock cycles after each move (0.5 s at 50 MHz); must be at least 1.
- T_TIMEOUT, 5000000: maximum number of cycles to wait for `pronto_medida`; used only with SERVO_TIMEOUT_EN; must be at least 1.

Ports:
- clock, in, 1: system clock (50 MHz).
- reset, in, 1: asynchronous, active-high reset.
- ligar, in, 1: level input; sweep runs while high.
- pronto_medida, in, 1: one-cycle pulse from the sensor when a measurement is complete.
- posicao, out, 5: current servo position index, fed to the PWM `largura` input.
- medir, out, 1: one-cycle measurement start pulse.
- sentido, out, 1: sweep direction; 0 = increasing, 1 = decreasing.
- fim_ciclo, out, 1: one-cycle pulse when an endpoint is reached and direction reverses.
- timeout, out, 1: one-cycle pulse when a measurement wait expires; constant 0 without the macro.
- db_estado, out, 3: current state encoding, for debug.

Behaviour:
- Interface: reset is `reset`, asynchronous, active-high; the clock is `clock`.
- Reset values:
  - state = INICIAL.
  - posicao = 0, sentido = 0.
  - Internal 32-bit counter = 0.
  - medir = fim_ciclo = timeout = 0.
- State encodings: INICIAL=0, ASSENTA=1, MEDE=2, AGUARDA=3, AVANCA=4. Codes 5–7 are unreachable and recover to INICIAL on the next clock.
- Global rule: `ligar`=0 sampled in any state → INICIAL on the next clock. This clears posicao, sentido and the counter, and takes priority over every other transition.
- INICIAL:
  - Holds posicao=0, sentido=0, counter=0.
  - `ligar`=1 → ASSENTA.
- ASSENTA:
  - Counter increments every cycle.
  - When counter == T_ASSENTAMENTO-1: clear counter → MEDE.
  - The state therefore lasts exactly T_ASSENTAMENTO cycles.
- MEDE:
  - Lasts one cycle; `medir`=1 (Moore output, decoded from the state register).
  - → AGUARDA with counter=0.
  - A `pronto_medida` arriving during MEDE is ignored.
- AGUARDA:
  - `pronto_medida`=1 → AVANCA.
  - Otherwise the counter increments; see the optional feature for timeout handling.
- AVANCA lasts one cycle and updates the position registers, then → ASSENTA with counter=0:
  - sentido=0, posicao < POS_MAX: posicao+1.
  - sentido=0, posicao == POS_MAX: sentido←1, posicao←POS_MAX-1, fim_ciclo pulse.
  - sentido=1, posicao > 0: posicao-1.
  - sentido=1, posicao == 0: sentido←0, posicao←1, fim_ciclo pulse.
- Endpoints are each measured once per pass.
- `fim_ciclo` is registered: it is high for the single cycle following AVANCA, coincident with the first ASSENTA cycle.
- `posicao` is registered and changes only in AVANCA, INICIAL or reset. It is never outside 0..POS_MAX.
- Latency: with `ligar` sampled high at edge e, the state is ASSENTA after e, and `medir` is high during the cycle following edge e+T_ASSENTAMENTO.
- Reset asserted mid-operation takes effect immediately, independent of the clock.

Optional Feature:
- Macro: SERVO_TIMEOUT_EN.
- Defined:
  - In AGUARDA, if the counter reaches T_TIMEOUT-1 without `pronto_medida` → AVANCA.
  - `timeout` is pulsed for one cycle, registered and coincident with the AVANCA cycle.
  - If `pronto_medida` and expiry occur in the same cycle, `pronto_medida` wins and there is no timeout pulse.
- Undefined: AGUARDA waits indefinitely; `timeout` is tied to 0 and the timeout compare logic is not synthesized.

Test Plan (bench parameters POS_MAX=3, T_ASSENTAMENTO=4, T_TIMEOUT=8):
1. Reset, then `ligar`=1 at edge e0 → db_estado=1 after e0; `medir`=1 for exactly one cycle after edge e0+4; posicao=0, sentido=0 throughout.
2. `pronto_medida` pulsed 2 cycles after `medir` → AVANCA for one cycle, then posicao=1; next `medir` 4 cycles after entering ASSENTA.
3. Full sweep, answering every `medir` after 1 cycle → measured positions are 0,1,2,3,2,1,0,1. `fim_ciclo` pulses after 3→2 (sentido becomes 1) and after 0→1 (sentido becomes 0). Exactly one `medir` per position visit.
4. `ligar`=0 while in AGUARDA at posicao=2 → INICIAL next cycle with posicao=0, sentido=0. A later `pronto_medida` causes no change; re-asserting `ligar` restarts from position 0.
5. No `pronto_medida` after `medir`:
   - With SERVO_TIMEOUT_EN: `timeout` pulses after 8 AGUARDA cycles and posicao advances by 1.
   - Without it: the state stays at 3 for 100+ cycles and `timeout` stays 0.
6. Reset asserted asynchronously mid-ASSENTA at posicao=2, sentido=1 → posicao=0, sentido=0, db_estado=0 immediately; all pulse outputs 0.

Source files
------------

// File: rtl/controle_varredura_servo.sv
// -----------------------------------------------------------------------------
// controle_varredura_servo
//
// Sweep sequencer ahead of the turret servo PWM stage. It moves the servo
// position index back and forth between 0 and POS_MAX. At each position it
// waits a settling time, then fires a one-cycle measurement request. It waits
// for the sensor's completion pulse before it steps to the next position.
//
// Optional feature (macro SERVO_TIMEOUT_EN):
//   defined   - the measurement wait gives up after T_TIMEOUT cycles, and
//               `timeout` pulses for one cycle
//   undefined - the wait is unbounded and `timeout` is tied to 0
//
// Ports:
//   clock         in   1  system clock
//   reset         in   1  asynchronous, active-high reset
//   ligar         in   1  level; the sweep runs while high
//   pronto_medida in   1  one-cycle pulse from the sensor, measurement done
//   posicao       out  5  current position index (PWM `largura` input)
//   medir         out  1  one-cycle measurement start pulse
//   sentido       out  1  sweep direction, 0 = increasing, 1 = decreasing
//   fim_ciclo     out  1  one-cycle pulse when an endpoint reverses direction
//   timeout       out  1  one-cycle pulse when a measurement wait expires
//   db_estado     out  3  current state encoding, for debug
// -----------------------------------------------------------------------------
module controle_varredura_servo #(
    parameter int unsigned POS_MAX        = 28,
    parameter int unsigned T_ASSENTAMENTO = 25000000,
    parameter int unsigned T_TIMEOUT      = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pronto_medida,
    output logic [4:0] posicao,
    output logic       medir,
    output logic       sentido,
    output logic       fim_ciclo,
    output logic       timeout,
    output logic [2:0] db_estado
);

    localparam logic [2:0] INICIAL = 3'd0;
    localparam logic [2:0] ASSENTA = 3'd1;
    localparam logic [2:0] MEDE    = 3'd2;
    localparam logic [2:0] AGUARDA = 3'd3;
    localparam logic [2:0] AVANCA  = 3'd4;

    localparam logic [4:0]  POS_FIM        = 5'(POS_MAX);
    localparam logic [31:0] ULTIMO_ASSENTA = 32'(T_ASSENTAMENTO - 1);

    logic [2:0]  estado_q,    estado_d;
    logic [31:0] contador_q,  contador_d;
    logic [4:0]  posicao_q,   posicao_d;
    logic        sentido_q,   sentido_d;
    logic        fim_ciclo_q, fim_ciclo_d;

`ifdef SERVO_TIMEOUT_EN
    localparam logic [31:0] ULTIMO_TIMEOUT = 32'(T_TIMEOUT - 1);
    logic        timeout_q,   timeout_d;
`endif

    // Next-state, counter and position computation for the sweep FSM.
    always_comb begin
        estado_d    = estado_q;
        contador_d  = contador_q;
        posicao_d   = posicao_q;
        sentido_d   = sentido_q;
        fim_ciclo_d = 1'b0;
`ifdef SERVO_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif
        // Dropping `ligar` overrides every other transition.
        if (!ligar) begin
            estado_d   = INICIAL;
            contador_d = 32'd0;
            posicao_d  = 5'd0;
            sentido_d  = 1'b0;
        end else begin
            case (estado_q)
                INICIAL: begin
                    contador_d = 32'd0;
                    posicao_d  = 5'd0;
                    sentido_d  = 1'b0;
                    estado_d   = ASSENTA;
                end
                ASSENTA: begin
                    if (contador_q == ULTIMO_ASSENTA) begin
                        contador_d = 32'd0;
                        estado_d   = MEDE;
                    end else begin
                        contador_d = contador_q + 32'd1;
                    end
                end
                MEDE: begin
                    // Any completion pulse seen here is ignored.
                    contador_d = 32'd0;
                    estado_d   = AGUARDA;
                end
                AGUARDA: begin
                    if (pronto_medida) begin
                        contador_d = 32'd0;
                        estado_d   = AVANCA;
`ifdef SERVO_TIMEOUT_EN
                    end else if (contador_q == ULTIMO_TIMEOUT) begin
                        contador_d = 32'd0;
                        timeout_d  = 1'b1;
                        estado_d   = AVANCA;
`endif
                    end else begin
                        contador_d = contador_q + 32'd1;
                    end
                end
                AVANCA: begin
                    contador_d = 32'd0;
                    estado_d   = ASSENTA;
                    // An endpoint is measured once. The sweep then reverses
                    // straight to its neighbour.
                    if (!sentido_q) begin
                        if (posicao_q >= POS_FIM) begin
                            sentido_d   = 1'b1;
                            posicao_d   = POS_FIM - 5'd1;
                            fim_ciclo_d = 1'b1;
                        end else begin
                            posicao_d = posicao_q + 5'd1;
                        end
                    end else begin
                        if (posicao_q == 5'd0) begin
                            sentido_d   = 1'b0;
                            posicao_d   = 5'd1;
                            fim_ciclo_d = 1'b1;
                        end else begin
                            posicao_d = posicao_q - 5'd1;
                        end
                    end
                end
                default: begin
                    // Codes 5-7 are unreachable. They recover to INICIAL.
                    estado_d   = INICIAL;
                    contador_d = 32'd0;
                    posicao_d  = 5'd0;
                    sentido_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counter and registered output flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= INICIAL;
            contador_q  <= 32'd0;
            posicao_q   <= 5'd0;
            sentido_q   <= 1'b0;
            fim_ciclo_q <= 1'b0;
`ifdef SERVO_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            posicao_q   <= posicao_d;
            sentido_q   <= sentido_d;
            fim_ciclo_q <= fim_ciclo_d;
`ifdef SERVO_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign posicao   = posicao_q;
    assign sentido   = sentido_q;
    assign fim_ciclo = fim_ciclo_q;
    assign db_estado = estado_q;
    // Moore output, decoded directly from the state register.
    assign medir     = (estado_q == MEDE);

`ifdef SERVO_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
